uart_hex_writer: RTL and testbench

Transmit-side message generator for the UART core, clocked in the clk_1kHz domain. On a start event it captures an 8-bit value and writes its ASCII hex rendering (default "0xHH\r\n") byte-by-byte into the UART TX FIFO through the write_uart / write_data port, with flow control on tx_full. It is the write-side counterpart of the received-byte display path and drives a PC terminal through the USB-RS232 link.

---
 rtl/uart_hex_writer.sv | 140 ++++++++++++++
 tb/tb_uart_hex_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_writer.sv
// uart_hex_writer
// Renders a captured 8-bit value as ASCII hex ("0xHH\r\n" by default) and
// writes it byte-by-byte into the UART TX FIFO, one strobe every other cycle,
// pausing while the (synchronized) FIFO-full flag is set.
//
// Ports:
//   clk_1kHz    block clock, rising edge
//   reset       asynchronous, active-high
//   start       rising edge requests one message
//   data_in     value to render, sampled on the accepted trigger
//   tx_full     TX FIFO full (100 MHz domain), two-flop synchronized here
//   write_uart  one-cycle write strobe per byte
//   write_data  byte to write, held until the next strobe
//   busy        message in progress
//   done        one-cycle pulse after the last byte's strobe
//   sent_count  completed messages, wrapping
module uart_hex_writer #(
    parameter int unsigned PREFIX_EN   = 1,
    parameter int unsigned CRLF_EN     = 1,
    parameter int unsigned AUTO_PERIOD = 0
) (
    input  logic        clk_1kHz,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  data_in,
    input  logic        tx_full,
    output logic        write_uart,
    output logic [7:0]  write_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] sent_count
);

    localparam int unsigned LEN       = 2 + 2 * PREFIX_EN + 2 * CRLF_EN;
    localparam logic [2:0]  LAST_IDX  = 3'(LEN - 1);
    // Without a prefix, byte 0 is the high nibble: shift into the full layout.
    localparam logic [2:0]  POS_OFS   = (PREFIX_EN != 0) ? 3'd0 : 3'd2;
    localparam logic [15:0] AUTO_LAST = (AUTO_PERIOD == 0) ? 16'd0 : 16'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [7:0]  shadow;
    logic        start_q;
    logic        tx_full_m;
    logic        tx_full_s;
    logic [15:0] auto_cnt;
    logic        auto_tick;
    logic        trigger;
    logic [2:0]  pos;
    logic [7:0]  cur_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        pos      = idx + POS_OFS;
        cur_char = 8'h00;
        case (pos)
            3'd0:    cur_char = 8'h30;
            3'd1:    cur_char = 8'h78;
            3'd2:    cur_char = hex_ascii(shadow[7:4]);
            3'd3:    cur_char = hex_ascii(shadow[3:0]);
            3'd4:    cur_char = 8'h0D;
            3'd5:    cur_char = 8'h0A;
            default: cur_char = 8'h00;
        endcase
    end

    always_comb begin
        auto_tick = (AUTO_PERIOD != 0) && (auto_cnt == AUTO_LAST);
        trigger   = (start & ~start_q) | auto_tick;
    end

    always_ff @(posedge clk_1kHz or posedge reset) begin
        if (reset) begin
            start_q   <= 1'b0;
            tx_full_m <= 1'b0;
            tx_full_s <= 1'b0;
            auto_cnt  <= '0;
        end else begin
            start_q   <= start;
            tx_full_m <= tx_full;
            tx_full_s <= tx_full_m;
            if (AUTO_PERIOD == 0 || auto_cnt == AUTO_LAST)
                auto_cnt <= '0;
            else
                auto_cnt <= auto_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_1kHz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            shadow     <= '0;
            write_uart <= 1'b0;
            write_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sent_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Triggers outside IDLE are dropped, not queued.
                    if (trigger) begin
                        shadow <= data_in;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= EMIT;
                    end
                end
                EMIT: begin
                    if (!tx_full_s) begin
                        write_uart <= 1'b1;
                        write_data <= cur_char;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    write_uart <= 1'b0;
                    if (idx == LAST_IDX) begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        sent_count <= sent_count + 16'd1;
                        state      <= IDLE;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= EMIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_writer.sv
// Testbench for uart_hex_writer: table-driven and random messages against a
// string-based message model, plus hand-written reset/start-hold/auto sequences.
module tb_uart_hex_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  data_in;
    logic        tx_full;
    logic        write_uart;
    logic [7:0]  write_data;
    logic        busy;
    logic        done;
    logic [15:0] sent_count;

    logic        write_uart2;
    logic [7:0]  write_data2;
    logic        busy2;
    logic        done2;
    logic [15:0] sent_count2;
    logic        start2   = 1'b0;
    logic        tx_full2 = 1'b0;
    logic [7:0]  data_in2 = 8'h0F;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_count;

    always #5 clk = ~clk;

    uart_hex_writer dut (
        .clk_1kHz  (clk),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .tx_full   (tx_full),
        .write_uart(write_uart),
        .write_data(write_data),
        .busy      (busy),
        .done      (done),
        .sent_count(sent_count)
    );

    uart_hex_writer #(
        .PREFIX_EN  (0),
        .CRLF_EN    (0),
        .AUTO_PERIOD(30)
    ) dut2 (
        .clk_1kHz  (clk),
        .reset     (reset),
        .start     (start2),
        .data_in   (data_in2),
        .tx_full   (tx_full2),
        .write_uart(write_uart2),
        .write_data(write_data2),
        .busy      (busy2),
        .done      (done2),
        .sent_count(sent_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference rendering of a message as a text string.
    function automatic string model_text(input logic [7:0] d, input bit p, input bit c);
        string digits;
        string s;
        int    hi;
        int    lo;
        digits = "0123456789ABCDEF";
        hi = int'(d[7:4]);
        lo = int'(d[3:0]);
        s = "";
        if (p) s = {s, "0x"};
        s = {s, digits.substr(hi, hi), digits.substr(lo, lo)};
        if (c) s = {s, "\r\n"};
        return s;
    endfunction

    // Runs one message on dut; stalls tx_full so the FSM sees it full for sl
    // cycles starting where byte sb would issue.
    task automatic run_msg(input logic [7:0] d, input int sb, input int sl,
                           input string exp, input int exp_done, input string tag);
        byte got[$];
        int  at[$];
        int  j;
        int  done_at;
        int  e;
        @(negedge clk);
        start = 1'b0; tx_full = 1'b0;
        @(negedge clk);
        data_in = d; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_busy_set"}, {31'd0, busy}, 1);
        start = 1'b0;
        data_in = ~d;
        j = 0; done_at = -1;
        while (done_at < 0 && j < 80) begin
            if (write_uart) begin got.push_back(write_data); at.push_back(j); end
            if (done) begin
                done_at = j;
            end else begin
                tx_full = (sl > 0) && (j + 1 >= 2 * sb - 1) && (j + 1 <= 2 * sb + sl - 2);
                @(negedge clk);
                j++;
            end
        end
        tx_full = 1'b0;
        chk({tag, "_done_at"}, done_at, exp_done);
        chk({tag, "_nbytes"}, got.size(), exp.len());
        for (int i = 0; i < exp.len() && i < got.size(); i++) begin
            e = 1 + 2 * i + ((i >= sb) ? sl : 0);
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
            chk($sformatf("%s_strobe_t%0d", tag, i), at[i], e);
        end
        if (done_at >= 0) begin
            exp_count = exp_count + 16'd1;
            chk({tag, "_busy_clr"}, {31'd0, busy}, 0);
            chk({tag, "_count"}, {16'd0, sent_count}, {16'd0, exp_count});
            @(negedge clk);
            chk({tag, "_done_pulse"}, {31'd0, done}, 0);
            chk({tag, "_data_held"}, {24'd0, write_data}, {24'd0, exp[exp.len() - 1]});
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         sb;
        int         sl;
        string      text;
        int         done_at;
    } vec_t;

    initial begin
        vec_t  vecs[4];
        byte   b2[$];
        int    n;
        int    j;
        int    t;
        int    d1;
        int    d2;
        logic [7:0] rd;
        int    rsb;
        int    rsl;
        string t2;

        vecs[0] = '{8'hA5, 1, 0, "0xA5\r\n", 12};
        vecs[1] = '{8'h3C, 2, 5, "0x3C\r\n", 17};
        vecs[2] = '{8'hFF, 1, 3, "0xFF\r\n", 15};
        vecs[3] = '{8'h09, 5, 1, "0x09\r\n", 13};

        reset = 1'b1; start = 1'b0; tx_full = 1'b0; data_in = 8'h00;
        exp_count = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("reset_idle", {5'd0, write_uart, write_data, busy, done, sent_count}, 0);
        end

        foreach (vecs[i])
            run_msg(vecs[i].data, vecs[i].sb, vecs[i].sl, vecs[i].text,
                    vecs[i].done_at, $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            rd  = 8'($urandom);
            rsb = int'($urandom_range(1, 5));
            rsl = int'($urandom_range(0, 6));
            run_msg(rd, rsb, rsl, model_text(rd, 1'b1, 1'b1), 12 + rsl, $sformatf("rnd%0d", i));
        end

        // start held high, with an extra edge mid-message: exactly one message.
        @(negedge clk);
        data_in = 8'h5A; start = 1'b1;
        @(posedge clk);
        n = 0; b2.delete();
        for (j = 0; j < 45; j++) begin
            @(negedge clk);
            if (write_uart) begin n++; b2.push_back(write_data); end
            if (j == 2) start = 1'b0;
            if (j == 3) start = 1'b1;
            if (j == 40) start = 1'b0;
        end
        exp_count = exp_count + 16'd1;
        chk("hold_nbytes", n, 6);
        t2 = model_text(8'h5A, 1'b1, 1'b1);
        for (int i = 0; i < 6 && i < b2.size(); i++)
            chk($sformatf("hold_byte%0d", i), {24'd0, b2[i]}, {24'd0, t2[i]});
        chk("hold_count", {16'd0, sent_count}, {16'd0, exp_count});

        // Asynchronous reset right after the third strobe.
        @(negedge clk);
        data_in = 8'h77; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0; j = 0;
        while (n < 3 && j < 40) begin
            @(negedge clk); j++;
            if (write_uart) n++;
        end
        chk("mid_third_strobe", {31'd0, write_uart}, 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_outputs", {5'd0, write_uart, write_data, busy, done, sent_count}, 0);
        exp_count = '0;
        @(negedge clk);
        reset = 1'b0;
        run_msg(8'h00, 1, 0, "0x00\r\n", 12, "after_reset");

        // Auto mode instance, with a forced wrap of sent_count.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        b2.delete(); t = 0; d1 = -1; d2 = -1;
        while (d1 < 0 && t < 60) begin
            @(negedge clk); t++;
            if (write_uart2) b2.push_back(write_data2);
            if (done2) d1 = t;
        end
        chk("auto_first_done", {31'd0, d1 >= 0}, 1);
        chk("auto_count1", {16'd0, sent_count2}, 1);
        force dut2.sent_count = 16'hFFFF;
        @(negedge clk); t++;
        if (write_uart2) b2.push_back(write_data2);
        release dut2.sent_count;
        while (d2 < 0 && t < 130) begin
            @(negedge clk); t++;
            if (write_uart2) b2.push_back(write_data2);
            if (done2) d2 = t;
        end
        chk("auto_period", d2 - d1, 30);
        chk("auto_wrap", {16'd0, sent_count2}, 0);
        t2 = {model_text(8'h0F, 1'b0, 1'b0), model_text(8'h0F, 1'b0, 1'b0)};
        chk("auto_nbytes", b2.size(), 4);
        for (int i = 0; i < 4 && i < b2.size(); i++)
            chk($sformatf("auto_byte%0d", i), {24'd0, b2[i]}, {24'd0, t2[i]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
